deint_block_ctrl: RTL and testbench

//   Sequencer for the ping-pong block deinterleaver RAM (two banks of ROWS*COLS bits).

---
 rtl/deint_block_ctrl.sv | 140 ++++++++++++++
 tb/tb_deint_block_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/deint_block_ctrl.sv
// Ping-pong block deinterleaver sequencer: writes the serial stream row-wise into one bank while
// reading the other bank in transposed order, then drains the final bank once the frame ends.
module deint_block_ctrl #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  localparam int N  = ROWS * COLS,
  localparam int AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          valid_recv,
  input  logic          data_i,
  input  logic          eof,
  output logic          in_ready,
  output logic          mem_wr_en,
  output logic          mem_wr_bank,
  output logic [AW-1:0] mem_wr_addr,
  output logic          mem_wr_data,
  output logic          mem_rd_en,
  output logic          mem_rd_bank,
  output logic [AW-1:0] mem_rd_addr,
  input  logic          mem_rd_data,
  output logic          data_o,
  output logic          valid_deco,
  output logic          blk_last,
  output logic          err,
  output logic [15:0]   blk_cnt
);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_t;

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  state_t        state;
  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] rd_cnt;
  logic          wr_bank;
  logic          drain_bank;
  logic          rd_last;
  logic          accept;
  logic          blk_end;

  // Column-major walk over a row-major block.
  function automatic logic [AW-1:0] transpose(input logic [AW-1:0] c);
    int ci;
    ci = int'(c);
    return AW'(ci / ROWS + (ci % ROWS) * COLS);
  endfunction

  assign in_ready = (state != DRAIN);
  assign accept   = valid_recv && in_ready;
  assign blk_end  = (wr_cnt == LAST) || eof;
  assign data_o   = mem_rd_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      wr_bank     <= 1'b0;
      drain_bank  <= 1'b0;
      rd_last     <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_bank <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_bank <= 1'b0;
      mem_rd_addr <= '0;
      valid_deco  <= 1'b0;
      blk_last    <= 1'b0;
      err         <= 1'b0;
      blk_cnt     <= '0;
    end else begin
      mem_wr_en  <= 1'b0;
      mem_rd_en  <= 1'b0;
      rd_last    <= 1'b0;
      // Output stage: RAM data arrives one cycle after the read strobe.
      valid_deco <= mem_rd_en;
      blk_last   <= mem_rd_en && rd_last;
      if (mem_rd_en && rd_last) blk_cnt <= blk_cnt + 16'd1;

      if (clr) begin
        state      <= IDLE;
        wr_cnt     <= '0;
        rd_cnt     <= '0;
        wr_bank    <= 1'b0;
        err        <= 1'b0;
        blk_cnt    <= '0;
        valid_deco <= 1'b0;
        blk_last   <= 1'b0;
      end else begin
        case (state)
          IDLE, FILL, STREAM: begin
            if (accept) begin
              mem_wr_en   <= 1'b1;
              mem_wr_bank <= wr_bank;
              mem_wr_addr <= wr_cnt;
              mem_wr_data <= data_i;
              if (state == STREAM) begin
                mem_rd_en   <= 1'b1;
                mem_rd_bank <= ~wr_bank;
                mem_rd_addr <= transpose(rd_cnt);
                rd_last     <= (rd_cnt == LAST);
              end
              // A short block (early eof) closes exactly like a full one.
              if (blk_end) begin
                if (eof && (wr_cnt != LAST)) err <= 1'b1;
                wr_bank    <= ~wr_bank;
                drain_bank <= wr_bank;
                wr_cnt     <= '0;
                rd_cnt     <= '0;
                state      <= eof ? DRAIN : STREAM;
              end else begin
                wr_cnt <= wr_cnt + 1'b1;
                if (state == STREAM) rd_cnt <= rd_cnt + 1'b1;
                if (state == IDLE) state <= FILL;
              end
            end
          end
          DRAIN: begin
            mem_rd_en   <= 1'b1;
            mem_rd_bank <= drain_bank;
            mem_rd_addr <= transpose(rd_cnt);
            rd_last     <= (rd_cnt == LAST);
            if (rd_cnt == LAST) begin
              rd_cnt <= '0;
              state  <= IDLE;
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_deint_block_ctrl.sv
// Scoreboard bench for deint_block_ctrl (4x4) with a behavioural ping-pong RAM.
module tb_deint_block_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       valid_recv = 1'b0;
  logic       data_i = 1'b0;
  logic       eof = 1'b0;
  logic       in_ready;
  logic       mem_wr_en, mem_wr_bank, mem_wr_data;
  logic [3:0] mem_wr_addr;
  logic       mem_rd_en, mem_rd_bank;
  logic [3:0] mem_rd_addr;
  logic       mem_rd_data = 1'b0;
  logic       data_o, valid_deco, blk_last, err;
  logic [15:0] blk_cnt;

  deint_block_ctrl #(.ROWS(4), .COLS(4)) dut (
    .clk(clk), .rst(rst), .clr(clr), .valid_recv(valid_recv), .data_i(data_i), .eof(eof),
    .in_ready(in_ready), .mem_wr_en(mem_wr_en), .mem_wr_bank(mem_wr_bank),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_rd_en(mem_rd_en),
    .mem_rd_bank(mem_rd_bank), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .data_o(data_o), .valid_deco(valid_deco), .blk_last(blk_last), .err(err), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic d;
    logic last;
    logic dc;
  } exp_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_blk = 0;
  bit   chk_stall = 1'b0;
  exp_t sbq[$];
  exp_t mon_e;
  int   tord[16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
  logic ram [2][16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Synchronous-read RAM, one-cycle latency
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_wr_bank][mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= ram[mem_rd_bank][mem_rd_addr];
  end

  always @(negedge clk) begin
    if (rst && valid_deco) begin
      if (sbq.size() == 0) begin
        check("unexpected_valid_deco", valid_deco, 0);
      end else begin
        mon_e = sbq.pop_front();
        if (!mon_e.dc) check("data_o", data_o, mon_e.d);
        check("blk_last", blk_last, mon_e.last);
        if (mon_e.last) exp_blk++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic d, input logic e, input logic v);
    valid_recv = v;
    data_i     = d;
    eof        = e;
    tick();
    valid_recv = 1'b0;
    eof        = 1'b0;
    if (!v && chk_stall) begin
      check("stall_wr_en", mem_wr_en, 0);
      check("stall_rd_en", mem_rd_en, 0);
    end
  endtask

  task automatic wait_drain(output int cyc);
    cyc = 0;
    while (!in_ready && cyc < 40) begin
      tick();
      cyc++;
    end
    check("drain_done", in_ready, 1);
    repeat (3) tick();
    check("sb_empty", sbq.size(), 0);
  endtask

  task automatic push_blocks(input logic bits[$], input int nb);
    exp_t e;
    for (int b = 0; b < nb; b++)
      for (int j = 0; j < 16; j++) begin
        e.d    = bits[b*16 + tord[j]];
        e.last = (j == 15);
        e.dc   = 1'b0;
        sbq.push_back(e);
      end
  endtask

  task automatic run_frame(input logic bits[$], input bit gaps, output int cyc);
    push_blocks(bits, bits.size() / 16);
    chk_stall = gaps;
    for (int i = 0; i < bits.size(); i++) begin
      if (gaps && $urandom_range(0, 1) == 1)
        repeat ($urandom_range(1, 2)) beat(1'b0, 1'b0, 1'b0);
      beat(bits[i], (i == bits.size() - 1), 1'b1);
    end
    chk_stall = 1'b0;
    wait_drain(cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic bits[$];
    int   cyc;
    int   rds;
    exp_t e;

    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_valid", valid_deco, 0);
    check("rst_err", err, 0);
    check("rst_blk_cnt", blk_cnt, 0);
    rst = 1'b1;
    tick();

    // 1: alternating bits, two blocks
    bits.delete();
    for (int i = 0; i < 32; i++) bits.push_back(1'(i % 2));
    run_frame(bits, 1'b0, cyc);
    check("t1_blk_cnt", blk_cnt, 2);
    check("t1_err", err, 0);

    // 2: single block, one-hot at input 1
    bits.delete();
    for (int i = 0; i < 16; i++) bits.push_back(i == 1);
    run_frame(bits, 1'b0, cyc);
    check("t2_drain_len", cyc, 16);
    check("t2_blk_cnt", blk_cnt, exp_blk);

    // 4: early eof at beat 9
    bits.delete();
    for (int i = 0; i < 10; i++) bits.push_back(1'($urandom_range(0, 1)));
    for (int j = 0; j < 16; j++) begin
      e.d    = (tord[j] < 10) ? bits[tord[j]] : 1'b0;
      e.dc   = (tord[j] >= 10);
      e.last = (j == 15);
      sbq.push_back(e);
    end
    for (int i = 0; i < 9; i++) beat(bits[i], 1'b0, 1'b1);
    check("t4_err_before", err, 0);
    beat(bits[9], 1'b1, 1'b1);
    check("t4_err_set", err, 1);
    wait_drain(cyc);
    repeat (5) tick();
    check("t4_err_hold", err, 1);
    check("t4_blk_cnt", blk_cnt, exp_blk);

    // 6: clr together with eof
    for (int i = 0; i < 5; i++) beat(1'b1, 1'b0, 1'b1);
    valid_recv = 1'b1;
    eof        = 1'b1;
    clr        = 1'b1;
    tick();
    clr        = 1'b0;
    valid_recv = 1'b0;
    eof        = 1'b0;
    exp_blk    = 0;
    rds = 0;
    repeat (20) begin
      tick();
      if (mem_rd_en) rds++;
    end
    check("t6_no_reads", rds, 0);
    check("t6_in_ready", in_ready, 1);
    check("t6_err_clr", err, 0);
    check("t6_blk_cnt", blk_cnt, 0);

    // 3: three blocks with random stalls
    bits.delete();
    for (int i = 0; i < 48; i++) bits.push_back(1'($urandom_range(0, 1)));
    run_frame(bits, 1'b1, cyc);
    check("t3_blk_cnt", blk_cnt, 3);

    // 5: asynchronous reset in the middle of the second block
    bits.delete();
    for (int i = 0; i < 32; i++) bits.push_back(1'($urandom_range(0, 1)));
    push_blocks(bits, 1);
    for (int i = 0; i < 24; i++) beat(bits[i], 1'b0, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    sbq.delete();
    exp_blk = 0;
    check("t5_in_ready", in_ready, 1);
    check("t5_wr_en", mem_wr_en, 0);
    check("t5_rd_en", mem_rd_en, 0);
    check("t5_rd_addr", mem_rd_addr, 0);
    check("t5_valid", valid_deco, 0);
    check("t5_blk_last", blk_last, 0);
    check("t5_blk_cnt", blk_cnt, 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    bits.delete();
    for (int i = 0; i < 16; i++) bits.push_back(1'($urandom_range(0, 1)));
    run_frame(bits, 1'b0, cyc);
    check("t5_fresh_blk_cnt", blk_cnt, 1);
    check("t5_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
